regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor of the core's integer register file: two combinational read ports, one write port, hardwired zero register, write-to-read bypass and a per-register pending scoreboard for hazard detection.
- After reset, a sequential init engine loads every entry over DEPTH cycles instead of in one cycle.
- Sits between decode (reads, issue) and writeback (write) in the pipelined core.
- All state updates on the rising edge of clk.

Parameters:
DATA_WIDTH, 32, width of each register
ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH entries
INIT_MODE, 1, 0 = init all entries to zero; 1 = init entry i to value i (zero-extended/truncated to DATA_WIDTH); entry 0 always 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
src1_address  in  ADDR_WIDTH  read port 1 address
src2_address  in  ADDR_WIDTH  read port 2 address
write_enable  in  1  writeback strobe
address  in  ADDR_WIDTH  writeback address
data  in  DATA_WIDTH  writeback data
issue_enable  in  1  instruction issued that will write issue_address
issue_address  in  ADDR_WIDTH  destination of issued instruction
reg1  out  DATA_WIDTH  read data port 1
reg2  out  DATA_WIDTH  read data port 2
busy1  out  1  src1_address has a pending producer
busy2  out  1  src2_address has a pending producer
ready  out  1  init complete, block accepts traffic

Behaviour:
- Clocking/reset: single clock; rst is synchronous, active-high, sampled on rising clk.
- FSM states: INIT, RUN.
- rst=1 at any edge, including mid-INIT or during RUN: next state INIT, init counter = 0, all pending bits cleared, ready=0 next cycle. In-flight write/issue that cycle is dropped.
- INIT:
  - Each cycle writes entry[cnt] with its init value (per INIT_MODE), then cnt increments.
  - When cnt == DEPTH-1 has been written, go to RUN; ready=1 from the following cycle.
  - INIT therefore lasts exactly DEPTH cycles after rst deasserts.
  - write_enable and issue_enable are ignored; reg1/reg2 read 0; busy1/busy2 read 0.
- RUN:
  - Write: write_enable=1 and address!=0 updates entry[address] with data at the edge; writes to 0 are discarded.
  - Reads: reg1/reg2 are combinational from src addresses. Address 0 always returns 0.
  - Bypass: if write_enable=1, address!=0 and address==srcN_address, regN returns data in the same cycle (write-first). Both ports may bypass simultaneously.
  - Scoreboard: issue_enable=1 with issue_address!=0 sets pending[issue_address]. A write with address!=0 clears pending[address].
  - Same-cycle issue and write to the same address: pending stays set (the new producer wins).
  - Pending[0] is never set.
  - busyN = pending[srcN_address] & ~(write_enable & address==srcN_address & address!=0). The in-flight write clears visible busy combinationally, consistent with bypass.
- Outputs after reset edge: ready=0, busy1=0, busy2=0, reg1=0, reg2=0 until RUN.
- Widths: no arithmetic beyond the ADDR_WIDTH-bit init counter. The counter must not wrap into a second init pass; the terminal test is on DEPTH-1.

Test Plan:
- Init: assert rst 1 cycle, release → ready=0 for exactly 32 cycles then 1; with INIT_MODE=1, reading 7 gives 7 and 31 gives 31; with INIT_MODE=0, reading 31 gives 0.
- Zero register: write 0xDEADBEEF to address 0, then read src1=0 → reg1=0; issue to address 0 → busy stays 0.
- Bypass: write 0x12345678 to r5 while src1=src2=5 → reg1=reg2=0x12345678 in that cycle; next cycle, with no write, both still read 0x12345678.
- Scoreboard: issue r9, then src1=9 → busy1=1; write r9=0xA5 → busy1=0 in the write cycle and reg1=0xA5; issue r3 and write r3 in the same cycle → busy on r3 remains 1 next cycle.
- Reset mid-operation: pending r4 set and r4=0x55; assert rst during RUN, then again at init cycle 10 → ready low for 32 cycles after the last release, busy on r4=0, r4 equals its init value, writes during INIT have no effect.
- Parameter sweep: DATA_WIDTH=16, ADDR_WIDTH=3 → init lasts 8 cycles, entry 7 reads 7, and a write to r7 bypasses correctly.

Source files
------------

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Integer register file with two read ports, one write port, a
//            zero register, write-first bypass, a pending-producer scoreboard
//            and a sequential post-reset init engine.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int INIT_MODE  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] src1_address,
  input  logic [ADDR_WIDTH-1:0] src2_address,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  issue_enable,
  input  logic [ADDR_WIDTH-1:0] issue_address,
  output logic [DATA_WIDTH-1:0] reg1,
  output logic [DATA_WIDTH-1:0] reg2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  ready
);

  localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ENTRY = '1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic [DATA_WIDTH-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]        pending;

  logic                    running;
  logic                    wr_hit;
  logic                    iss_hit;
  logic [DATA_WIDTH-1:0]   init_value;

  assign running    = (state == ST_RUN);
  assign wr_hit     = write_enable && (address != '0);
  assign iss_hit    = issue_enable && (issue_address != '0);
  assign init_value = (INIT_MODE == 1) ? DATA_WIDTH'(init_cnt) : '0;

  // Counter stops on the terminal entry so it never starts a second pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == LAST_ENTRY) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          ready <= 1'b1;
        end
        default: begin
          state    <= ST_INIT;
          init_cnt <= '0;
          ready    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        regs[init_cnt] <= init_value;
      end else if (wr_hit) begin
        regs[address] <= data;
      end
    end
  end

  // Set after clear: a same-cycle issue to the written register keeps it pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (running) begin
      if (wr_hit) begin
        pending[address] <= 1'b0;
      end
      if (iss_hit) begin
        pending[issue_address] <= 1'b1;
      end
    end
  end

  always_comb begin
    reg1  = '0;
    reg2  = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (running) begin
      if (src1_address != '0) begin
        reg1 = (wr_hit && (address == src1_address)) ? data : regs[src1_address];
      end
      if (src2_address != '0) begin
        reg2 = (wr_hit && (address == src2_address)) ? data : regs[src2_address];
      end
      busy1 = pending[src1_address] && !(wr_hit && (address == src1_address));
      busy2 = pending[src2_address] && !(wr_hit && (address == src2_address));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// Directed self-checking bench for regfile_scoreboard: default, zero-init and
// narrow (16-bit data, 8-entry) instances.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  src1, src2, waddr, iaddr;
  logic        we, ie;
  logic [31:0] wdata;
  logic [31:0] r1, r2, z1, z2;
  logic        b1, b2, rdy, zb1, zb2, zrdy;

  logic [2:0]  s_src1, s_src2, s_waddr, s_iaddr;
  logic        s_we, s_ie;
  logic [15:0] s_wdata, s_r1, s_r2;
  logic        s_b1, s_b2, s_rdy;

  int errors = 0;
  int checks = 0;
  int n;
  int n_small;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .INIT_MODE(1)) dut (
    .clk(clk), .rst(rst), .src1_address(src1), .src2_address(src2),
    .write_enable(we), .address(waddr), .data(wdata),
    .issue_enable(ie), .issue_address(iaddr),
    .reg1(r1), .reg2(r2), .busy1(b1), .busy2(b2), .ready(rdy));

  regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .INIT_MODE(0)) dut_zero (
    .clk(clk), .rst(rst), .src1_address(src1), .src2_address(src2),
    .write_enable(we), .address(waddr), .data(wdata),
    .issue_enable(ie), .issue_address(iaddr),
    .reg1(z1), .reg2(z2), .busy1(zb1), .busy2(zb2), .ready(zrdy));

  regfile_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .INIT_MODE(1)) dut_small (
    .clk(clk), .rst(rst), .src1_address(s_src1), .src2_address(s_src2),
    .write_enable(s_we), .address(s_waddr), .data(s_wdata),
    .issue_enable(s_ie), .issue_address(s_iaddr),
    .reg1(s_r1), .reg2(s_r2), .busy1(s_b1), .busy2(s_b2), .ready(s_rdy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step to the next negedge, where inputs change and outputs are sampled.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; src1 = 5'd7; src2 = 5'd31; waddr = '0; iaddr = '0;
    we = 1'b0; ie = 1'b0; wdata = '0;
    s_src1 = 3'd7; s_src2 = 3'd7; s_waddr = '0; s_iaddr = '0;
    s_we = 1'b0; s_ie = 1'b0; s_wdata = '0;
    repeat (2) @(posedge clk);
    nxt(); #1;
    chk("reset_ready", {31'd0, rdy}, 32'd0);
    chk("reset_reg1", r1, 32'd0);
    chk("reset_busy1", {31'd0, b1}, 32'd0);

    // First init pass: measure both init lengths.
    rst = 1'b0;
    n = 0; n_small = -1;
    while (!rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (s_rdy && n_small < 0) n_small = n;
    end
    chk("init_len_32", n, 32);
    chk("init_len_8", n_small, 8);

    nxt(); #1;
    chk("init_r7", r1, 32'd7);
    chk("init_r31", r2, 32'd31);
    chk("zero_mode_r7", z1, 32'd0);
    chk("zero_mode_r31", z2, 32'd0);
    chk("small_r7", {16'd0, s_r1}, 32'd7);

    // Zero register.
    src1 = 5'd0; we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF; #1;
    chk("zero_bypass", r1, 32'd0);
    nxt(); we = 1'b0; #1;
    chk("zero_read", r1, 32'd0);
    ie = 1'b1; iaddr = 5'd0;
    nxt(); ie = 1'b0; #1;
    chk("zero_busy", {31'd0, b1}, 32'd0);

    // Bypass on both ports.
    src1 = 5'd5; src2 = 5'd5; we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; #1;
    chk("bypass_reg1", r1, 32'h12345678);
    chk("bypass_reg2", r2, 32'h12345678);
    nxt(); we = 1'b0; #1;
    chk("stored_reg1", r1, 32'h12345678);
    chk("stored_reg2", r2, 32'h12345678);

    // Scoreboard set, clear-with-bypass, and issue/write collision.
    ie = 1'b1; iaddr = 5'd9;
    nxt(); ie = 1'b0; src1 = 5'd9; #1;
    chk("pend_r9", {31'd0, b1}, 32'd1);
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5; #1;
    chk("clear_busy_r9", {31'd0, b1}, 32'd0);
    chk("clear_data_r9", r1, 32'hA5);
    nxt(); we = 1'b0; #1;
    chk("after_clear_r9", {31'd0, b1}, 32'd0);
    ie = 1'b1; iaddr = 5'd3; we = 1'b1; waddr = 5'd3; wdata = 32'h33;
    nxt(); ie = 1'b0; we = 1'b0; src2 = 5'd3; #1;
    chk("collide_busy_r3", {31'd0, b2}, 32'd1);
    chk("collide_data_r3", r2, 32'h33);

    // Pending r4 holding 0x55, then reset during RUN and again mid-INIT.
    we = 1'b1; waddr = 5'd4; wdata = 32'h55;
    nxt(); we = 1'b0; ie = 1'b1; iaddr = 5'd4;
    nxt(); ie = 1'b0; src1 = 5'd4; #1;
    chk("pre_rst_busy_r4", {31'd0, b1}, 32'd1);
    chk("pre_rst_r4", r1, 32'h55);
    rst = 1'b1;
    nxt(); rst = 1'b0;
    repeat (10) @(posedge clk);
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0;
    we = 1'b1; waddr = 5'd4; wdata = 32'hFF; ie = 1'b1; iaddr = 5'd4; #1;
    chk("init_reg1_zero", r1, 32'd0);
    chk("init_busy1_zero", {31'd0, b1}, 32'd0);
    chk("init_ready_low", {31'd0, rdy}, 32'd0);
    n = 0;
    while (!rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reinit_len_32", n, 32);
    nxt(); we = 1'b0; ie = 1'b0; #1;
    chk("post_rst_busy_r4", {31'd0, b1}, 32'd0);
    chk("post_rst_r4", r1, 32'd4);

    // Narrow instance bypass on r7.
    s_we = 1'b1; s_waddr = 3'd7; s_wdata = 16'hBEEF; #1;
    chk("small_bypass1", {16'd0, s_r1}, 32'hBEEF);
    chk("small_bypass2", {16'd0, s_r2}, 32'hBEEF);
    nxt(); s_we = 1'b0; #1;
    chk("small_stored", {16'd0, s_r1}, 32'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
